// File: rtl/gain_filter_scheduler_pkg.sv
// Shared constants and elaboration-time helpers for the gain filter scheduler.
package gain_filter_scheduler_pkg;

    localparam int DEF_NCHAN       = 4;
    localparam int DEF_DATA_WIDTH  = 30;
    localparam int DEF_SHIFT_WIDTH = 3;

    // Ceiling log2, at least 1 so a channel index always has a bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Headroom bits added below the sample so the largest shift loses no precision.
    function automatic int widen_of(input int shift_width);
        return (1 << shift_width) - 1;
    endfunction

endpackage

// File: rtl/gain_filter_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible channel after the last winner.
module rr_arbiter
    import gain_filter_scheduler_pkg::*;
#(
    parameter int NCHAN      = DEF_NCHAN,
    parameter int CHAN_WIDTH = clog2(DEF_NCHAN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic [NCHAN-1:0]      request,
    input  logic [NCHAN-1:0]      mask,
    output logic [NCHAN-1:0]      grant,
    output logic [CHAN_WIDTH-1:0] grant_idx,
    output logic                  grant_valid
);

    logic [CHAN_WIDTH-1:0] pointer;
    logic [NCHAN-1:0]      eligible;

    assign eligible = request & ~mask;

    // Search starts one past the previous winner and wraps, so every channel gets a turn.
    always_comb begin
        logic [CHAN_WIDTH-1:0] cand;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 1; i <= NCHAN; i++) begin
            cand = CHAN_WIDTH'((int'(pointer) + i) % NCHAN);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    // Pointer starts at the last channel so channel 0 wins first; it only moves on a real grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pointer <= CHAN_WIDTH'(NCHAN - 1);
        end else if (advance && grant_valid) begin
            pointer <= grant_idx;
        end
    end

endmodule

// File: rtl/gain_filter_scheduler.sv
// One first-order low-pass gain filter shared round-robin across NCHAN sample streams.
module gain_filter_scheduler
    import gain_filter_scheduler_pkg::*;
#(
    parameter int NCHAN       = DEF_NCHAN,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int CHAN_WIDTH  = clog2(DEF_NCHAN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SHIFT_WIDTH-1:0]      filterShift,
    input  logic                        clear,
    input  logic [NCHAN-1:0]            S_TVALID,
    input  logic [NCHAN*DATA_WIDTH-1:0] S_TDATA,
    input  logic [NCHAN-1:0]            overrunClear,
    output logic                        M_TVALID,
    output logic [DATA_WIDTH-1:0]       M_TDATA,
    output logic [CHAN_WIDTH-1:0]       M_TCHAN,
    output logic [NCHAN-1:0]            overrun,
    output logic                        busy
);

    localparam int WIDEN     = widen_of(SHIFT_WIDTH);
    localparam int SUM_WIDTH = DATA_WIDTH + WIDEN;

    logic [DATA_WIDTH-1:0]  hold [NCHAN];
    logic [SUM_WIDTH-1:0]   sum  [NCHAN];
    logic [NCHAN-1:0]       pending;

    logic                   s1_valid;
    logic [CHAN_WIDTH-1:0]  s1_chan;
    logic [DATA_WIDTH-1:0]  s1_data;
    logic [SUM_WIDTH-1:0]   s1_sum;
    logic [SHIFT_WIDTH-1:0] s1_shift;

    logic [NCHAN-1:0]       mask;
    logic [NCHAN-1:0]       grant;
    logic [CHAN_WIDTH-1:0]  grant_idx;
    logic                   grant_valid;

    logic [SHIFT_WIDTH-1:0] left_shift;
    logic [SUM_WIDTH-1:0]   scaled;
    logic [SUM_WIDTH-1:0]   leaked;
    logic [SUM_WIDTH-1:0]   new_sum;

    // The channel sitting in stage 1 is blocked so its next op sees the written-back sum.
    always_comb begin
        mask = '0;
        if (s1_valid) mask[s1_chan] = 1'b1;
    end

    rr_arbiter #(
        .NCHAN      (NCHAN),
        .CHAN_WIDTH (CHAN_WIDTH)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (!clear),
        .request     (pending),
        .mask        (mask),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign left_shift = SHIFT_WIDTH'(WIDEN) - s1_shift;
    assign scaled     = {{WIDEN{1'b0}}, s1_data} << left_shift;
    assign leaked     = s1_sum - (s1_sum >> s1_shift);
    assign new_sum    = scaled + leaked;

    assign busy = (|pending) || s1_valid;

    // Capture arrivals into hold registers; newest sample wins and an unserved overwrite is flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCHAN; c++) hold[c] <= '0;
            pending <= '0;
            overrun <= '0;
        end else if (clear) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (S_TVALID[c]) begin
                    hold[c]    <= S_TDATA[c*DATA_WIDTH +: DATA_WIDTH];
                    pending[c] <= 1'b1;
                end else if (grant[c]) begin
                    pending[c] <= 1'b0;
                end
                if (S_TVALID[c] && pending[c] && !grant[c]) begin
                    overrun[c] <= 1'b1;
                end else if (overrunClear[c]) begin
                    overrun[c] <= 1'b0;
                end
            end
        end
    end

    // Stage 1 snapshots the granted channel's sample, accumulator and the current pole.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_chan  <= '0;
            s1_data  <= '0;
            s1_sum   <= '0;
            s1_shift <= '0;
        end else begin
            s1_valid <= grant_valid && !clear;
            if (grant_valid) begin
                s1_chan  <= grant_idx;
                s1_data  <= hold[grant_idx];
                s1_sum   <= sum[grant_idx];
                s1_shift <= filterShift;
            end
        end
    end

    // Stage 2 writes the new accumulator back and presents its top DATA_WIDTH bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCHAN; c++) sum[c] <= '0;
            M_TVALID <= 1'b0;
            M_TDATA  <= '0;
            M_TCHAN  <= '0;
        end else if (clear) begin
            for (int c = 0; c < NCHAN; c++) sum[c] <= '0;
            M_TVALID <= 1'b0;
        end else begin
            M_TVALID <= s1_valid;
            if (s1_valid) begin
                sum[s1_chan] <= new_sum;
                M_TCHAN      <= s1_chan;
                M_TDATA      <= new_sum[WIDEN +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_gain_filter_scheduler.sv
// Directed bench for gain_filter_scheduler with hand-computed expected results.
module tb_gain_filter_scheduler;

    localparam int NCHAN = 4;
    localparam int DW    = 30;
    localparam int SW    = 3;
    localparam int CW    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [SW-1:0]     filterShift = '0;
    logic              clear = 1'b0;
    logic [NCHAN-1:0]  S_TVALID = '0;
    logic [NCHAN*DW-1:0] S_TDATA = '0;
    logic [NCHAN-1:0]  overrunClear = '0;
    logic              M_TVALID;
    logic [DW-1:0]     M_TDATA;
    logic [CW-1:0]     M_TCHAN;
    logic [NCHAN-1:0]  overrun;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    gain_filter_scheduler #(
        .NCHAN       (NCHAN),
        .DATA_WIDTH  (DW),
        .SHIFT_WIDTH (SW),
        .CHAN_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .filterShift  (filterShift),
        .clear        (clear),
        .S_TVALID     (S_TVALID),
        .S_TDATA      (S_TDATA),
        .overrunClear (overrunClear),
        .M_TVALID     (M_TVALID),
        .M_TDATA      (M_TDATA),
        .M_TCHAN      (M_TCHAN),
        .overrun      (overrun),
        .busy         (busy)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input int c, input logic [DW-1:0] v);
        S_TVALID[c] = 1'b1;
        S_TDATA[c*DW +: DW] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (M_TVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b expected 0", M_TVALID); end
        n_checks++; if (M_TDATA !== '0) begin n_fail++; $display("[TB] FAIL reset_data: got %0d expected 0", M_TDATA); end
        n_checks++; if (M_TCHAN !== '0) begin n_fail++; $display("[TB] FAIL reset_chan: got %0d expected 0", M_TCHAN); end
        n_checks++; if (overrun !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b expected 0000", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        filterShift = 3'd0;
        set_sample(0, 30'd1000);
        tick();
        S_TVALID = '0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL pass_busy: got %0b expected 1", busy); end
        n_checks++; if (M_TVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_early0: got %0b expected 0", M_TVALID); end
        tick();
        n_checks++; if (M_TVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_early1: got %0b expected 0", M_TVALID); end
        tick();
        n_checks++; if (M_TVALID !== 1'b1) begin n_fail++; $display("[TB] FAIL pass_valid: got %0b expected 1", M_TVALID); end
        n_checks++; if (M_TCHAN !== 2'd0) begin n_fail++; $display("[TB] FAIL pass_chan: got %0d expected 0", M_TCHAN); end
        n_checks++; if (M_TDATA !== 30'd1000) begin n_fail++; $display("[TB] FAIL pass_data: got %0d expected 1000", M_TDATA); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_idle: got %0b expected 0", busy); end
        tick();
        n_checks++; if (M_TVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL pass_single: got %0b expected 0", M_TVALID); end
    endtask

    task automatic test_decay();
        int e [5] = '{500, 750, 875, 937, 968};
        filterShift = 3'd1;
        for (int k = 0; k < 5; k++) begin
            set_sample(2, 30'd1000);
            tick();
            S_TVALID = '0;
            tick();
            tick();
            n_checks++; if (M_TVALID !== 1'b1 || M_TCHAN !== 2'd2) begin n_fail++; $display("[TB] FAIL decay_strobe%0d: got valid=%0b chan=%0d expected valid=1 chan=2", k, M_TVALID, M_TCHAN); end
            n_checks++; if (M_TDATA !== DW'(e[k])) begin n_fail++; $display("[TB] FAIL decay_data%0d: got %0d expected %0d", k, M_TDATA, e[k]); end
            tick();
        end
        set_sample(3, 30'd1000);
        tick();
        S_TVALID = '0;
        tick();
        tick();
        n_checks++; if (M_TVALID !== 1'b1 || M_TCHAN !== 2'd3 || M_TDATA !== 30'd500) begin n_fail++; $display("[TB] FAIL decay_other: got valid=%0b chan=%0d data=%0d expected 1/3/500", M_TVALID, M_TCHAN, M_TDATA); end
        tick();
    endtask

    task automatic test_round_robin();
        int ec [4] = '{2, 3, 0, 1};
        int ed [4] = '{30, 40, 10, 20};
        filterShift = 3'd0;
        set_sample(1, 30'd5);
        tick();
        S_TVALID = '0;
        tick();
        tick();
        n_checks++; if (M_TVALID !== 1'b1 || M_TCHAN !== 2'd1 || M_TDATA !== 30'd5) begin n_fail++; $display("[TB] FAIL rr_prep: got valid=%0b chan=%0d data=%0d expected 1/1/5", M_TVALID, M_TCHAN, M_TDATA); end
        tick();
        set_sample(0, 30'd10);
        set_sample(1, 30'd20);
        set_sample(2, 30'd30);
        set_sample(3, 30'd40);
        tick();
        S_TVALID = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (M_TVALID !== 1'b1 || M_TCHAN !== CW'(ec[k]) || M_TDATA !== DW'(ed[k])) begin n_fail++; $display("[TB] FAIL rr_out%0d: got valid=%0b chan=%0d data=%0d expected 1/%0d/%0d", k, M_TVALID, M_TCHAN, M_TDATA, ec[k], ed[k]); end
        end
        n_checks++; if (overrun !== 4'b0000) begin n_fail++; $display("[TB] FAIL rr_overrun: got %b expected 0000", overrun); end
        tick();
        n_checks++; if (M_TVALID !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_drain: got valid=%0b busy=%0b expected 0/0", M_TVALID, busy); end
    endtask

    task automatic test_overrun();
        int ec [4] = '{2, 3, 0, 1};
        int ed [4] = '{3, 99, 1, 2};
        filterShift = 3'd0;
        set_sample(0, 30'd1);
        set_sample(1, 30'd2);
        set_sample(2, 30'd3);
        set_sample(3, 30'd4);
        tick();
        S_TVALID = '0;
        set_sample(3, 30'd99);
        tick();
        S_TVALID = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (M_TVALID !== 1'b1 || M_TCHAN !== CW'(ec[k]) || M_TDATA !== DW'(ed[k])) begin n_fail++; $display("[TB] FAIL ovr_out%0d: got valid=%0b chan=%0d data=%0d expected 1/%0d/%0d", k, M_TVALID, M_TCHAN, M_TDATA, ec[k], ed[k]); end
        end
        tick();
        n_checks++; if (M_TVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_extra: got %0b expected 0", M_TVALID); end
        n_checks++; if (overrun !== 4'b1000) begin n_fail++; $display("[TB] FAIL ovr_flag: got %b expected 1000", overrun); end
        overrunClear = 4'b1000;
        tick();
        overrunClear = '0;
        n_checks++; if (overrun !== 4'b0000) begin n_fail++; $display("[TB] FAIL ovr_clear: got %b expected 0000", overrun); end
    endtask

    task automatic test_back_to_back();
        int e [4] = '{500, 750, 875, 937};
        clear = 1'b1;
        tick();
        clear = 1'b0;
        filterShift = 3'd1;
        set_sample(0, 30'd1000);
        tick();
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j % 2 == 0) begin
                n_checks++; if (M_TVALID !== 1'b1 || M_TCHAN !== 2'd0 || M_TDATA !== DW'(e[j/2-1])) begin n_fail++; $display("[TB] FAIL b2b_out%0d: got valid=%0b chan=%0d data=%0d expected 1/0/%0d", j, M_TVALID, M_TCHAN, M_TDATA, e[j/2-1]); end
            end else begin
                n_checks++; if (M_TVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_gap%0d: got %0b expected 0", j, M_TVALID); end
            end
        end
        S_TVALID = '0;
        tick();
        tick();
        tick();
        n_checks++; if (overrun !== 4'b0001) begin n_fail++; $display("[TB] FAIL b2b_overrun: got %b expected 0001", overrun); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle: got %0b expected 0", busy); end
        overrunClear = 4'b1111;
        tick();
        overrunClear = '0;
    endtask

    task automatic test_clear_and_reset();
        int ed [4] = '{11, 22, 33, 44};
        filterShift = 3'd1;
        set_sample(1, 30'd777);
        tick();
        S_TVALID = '0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (M_TVALID !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_discard: got valid=%0b busy=%0b expected 0/0", M_TVALID, busy); end
        tick();
        n_checks++; if (M_TVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_late: got %0b expected 0", M_TVALID); end
        set_sample(1, 30'd1000);
        tick();
        S_TVALID = '0;
        tick();
        tick();
        n_checks++; if (M_TVALID !== 1'b1 || M_TCHAN !== 2'd1 || M_TDATA !== 30'd500) begin n_fail++; $display("[TB] FAIL clr_next: got valid=%0b chan=%0d data=%0d expected 1/1/500", M_TVALID, M_TCHAN, M_TDATA); end
        tick();
        set_sample(1, 30'd777);
        tick();
        S_TVALID = '0;
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++; if (M_TVALID !== 1'b0 || M_TDATA !== '0 || M_TCHAN !== '0) begin n_fail++; $display("[TB] FAIL rst_out: got valid=%0b data=%0d chan=%0d expected 0/0/0", M_TVALID, M_TDATA, M_TCHAN); end
        n_checks++; if (busy !== 1'b0 || overrun !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_state: got busy=%0b overrun=%b expected 0/0000", busy, overrun); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (M_TVALID !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_nolate: got %0b expected 0", M_TVALID); end
        filterShift = 3'd0;
        set_sample(0, 30'd11);
        set_sample(1, 30'd22);
        set_sample(2, 30'd33);
        set_sample(3, 30'd44);
        tick();
        S_TVALID = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++; if (M_TVALID !== 1'b1 || M_TCHAN !== CW'(k) || M_TDATA !== DW'(ed[k])) begin n_fail++; $display("[TB] FAIL rst_order%0d: got valid=%0b chan=%0d data=%0d expected 1/%0d/%0d", k, M_TVALID, M_TCHAN, M_TDATA, k, ed[k]); end
        end
    endtask

    // Scenario sequence, then the single summary line.
    initial begin
        $display("[TB] starting gain_filter_scheduler directed tests");
        test_reset();
        test_passthrough();
        test_decay();
        test_round_robin();
        test_overrun();
        test_back_to_back();
        test_clear_and_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
